// File: rtl/slow_tick_sched_pkg.sv
// Shared types for the slow-waveform scheduler.
// Purely declarative: no latency or flow control of its own.
// Backpressure: none.
package slow_tick_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        HIGH = 3'd2,
        LOW  = 3'd3,
        DONE = 3'd4
    } sts_state_t;

    localparam int STS_MAX_REQ = 8;

    // Index width for a requester count; stays 1 bit wide for tiny configs.
    function automatic int sts_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slow_tick_sched_if.sv
// Requester-side bundle for slow_tick_sched: level requests, per-requester config, results.
// No registers; the abort line exists only with SLOW_TICK_SCHED_ABORT_EN.
// Backpressure: req is held by the client until its done pulse.
interface slow_tick_sched_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8,
    parameter int REP_W = 4
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] half_period;
    logic [N_REQ*REP_W-1:0] reps;
    logic [N_REQ-1:0]       grant;
    logic                   wave;
    logic                   busy;
    logic [N_REQ-1:0]       done;
`ifdef SLOW_TICK_SCHED_ABORT_EN
    logic                   abort;
`endif

    modport master (
`ifdef SLOW_TICK_SCHED_ABORT_EN
        output abort,
`endif
        output req, half_period, reps,
        input  grant, wave, busy, done
    );

    modport slave (
`ifdef SLOW_TICK_SCHED_ABORT_EN
        input  abort,
`endif
        input  req, half_period, reps,
        output grant, wave, busy, done
    );
endinterface

// File: rtl/slow_tick_sched_rr_arbiter.sv
// Round-robin pick: search starts one past the previous owner and wraps.
// Combinational, zero latency; no backpressure.
// valid_o is low when no request is pending.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_REQ-1:0] pick_o,
    output logic             valid_o
);
    always_comb begin
        pick_o  = '0;
        valid_o = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!valid_o && req_i[(int'(last_i) + k) % N_REQ]) begin
                pick_o[(int'(last_i) + k) % N_REQ] = 1'b1;
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/slow_tick_sched.sv
// Time-shares one rate divider across N_REQ clients; square wave of (hp+1)-cycle phases, reps+1 periods.
// Latency: LOAD one edge after req, wave one edge later, done after 1+2*(hp+1)*(reps+1) more edges.
// Backpressure: losers keep req high until granted; SLOW_TICK_SCHED_ABORT_EN adds an abort input.
module slow_tick_sched
    import slow_tick_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8,
    parameter int REP_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    slow_tick_sched_if.slave         bus
);
    localparam int IDX_W = sts_idx_w(N_REQ);

    sts_state_t        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  hp_q, hp_d;
    logic [REP_W-1:0]  reps_q, reps_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;

    logic [N_REQ-1:0]  pick;
    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx;
    logic [N_REQ-1:0]  owner_oh;
    logic              abort_w;

`ifdef SLOW_TICK_SCHED_ABORT_EN
    assign abort_w = bus.abort;
`else
    assign abort_w = 1'b0;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (bus.req),
        .last_i  (last_q),
        .pick_o  (pick),
        .valid_o (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) pick_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
            hp_q      <= '0;
            reps_q    <= '0;
            cnt_q     <= '0;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            hp_q      <= hp_d;
            reps_q    <= reps_d;
            cnt_q     <= cnt_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        hp_d      = hp_q;
        reps_d    = reps_q;
        cnt_d     = cnt_q;
        rep_cnt_d = rep_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_idx;
                    hp_d    = bus.half_period[int'(pick_idx)*CNT_W +: CNT_W];
                    reps_d  = bus.reps[int'(pick_idx)*REP_W +: REP_W];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d     = '0;
                rep_cnt_d = '0;
                state_d   = HIGH;
            end
            HIGH: begin
                if (cnt_q == hp_q) begin
                    cnt_d   = '0;
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOW: begin
                if (cnt_q == hp_q) begin
                    cnt_d = '0;
                    if (rep_cnt_q == reps_q) begin
                        state_d = DONE;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                        state_d   = HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort only cuts an active sequence short; it still ends through DONE.
        if (abort_w && (state_q == LOAD || state_q == HIGH || state_q == LOW)) begin
            state_d = DONE;
        end
    end

    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            owner_oh[i] = (owner_q == IDX_W'(i));
        end
    end

    assign bus.grant = (state_q != IDLE) ? owner_oh : '0;
    assign bus.done  = (state_q == DONE) ? owner_oh : '0;
    assign bus.wave  = (state_q == HIGH);
    assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_slow_tick_sched.sv
// Directed bench for slow_tick_sched: vector table for one full waveform, hand sequences for corner cases.
module tb_slow_tick_sched;
    localparam int N = 4;
    localparam int CW = 8;
    localparam int RW = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    slow_tick_sched_if #(.N_REQ(N), .CNT_W(CW), .REP_W(RW)) bus ();

    slow_tick_sched #(.N_REQ(N), .CNT_W(CW), .REP_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic       wave;
        logic       busy;
        logic [3:0] done;
    } vec_t;

    vec_t vt [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_cfg(input int i, input int hp, input int rp);
        logic [CW-1:0] h;
        logic [RW-1:0] r;
        h = CW'(hp);
        r = RW'(rp);
        bus.half_period[i*CW +: CW] = h;
        bus.reps[i*RW +: RW]        = r;
    endtask

    task automatic run_to_done(input int cycles);
        for (int c = 0; c < cycles; c++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [3:0] oh;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.req = '0;
        bus.half_period = '0;
        bus.reps = '0;
`ifdef SLOW_TICK_SCHED_ABORT_EN
        bus.abort = 1'b0;
`endif
        // req=0001 hp=2 reps=1: LOAD, 3 high, 3 low, 3 high, 3 low, DONE, IDLE
        vt = '{
            '{4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0000},
            '{4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0000},
            '{4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0000},
            '{4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0000},
            '{4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0000},
            '{4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0000},
            '{4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0000},
            '{4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0000},
            '{4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0000},
            '{4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0000},
            '{4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0000},
            '{4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0000},
            '{4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0000},
            '{4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0001},
            '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000}
        };

        #2;
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_wave",  32'(bus.wave),  32'h0);
        check("rst_busy",  32'(bus.busy),  32'h0);
        check("rst_done",  32'(bus.done),  32'h0);
        @(negedge clk);
        rst = 1'b0;

        set_cfg(0, 2, 1);
        for (int i = 0; i < 15; i++) begin
            bus.req = vt[i].req;
            tick();
            check($sformatf("tbl_grant[%0d]", i), 32'(bus.grant), 32'(vt[i].grant));
            check($sformatf("tbl_wave[%0d]", i),  32'(bus.wave),  32'(vt[i].wave));
            check($sformatf("tbl_busy[%0d]", i),  32'(bus.busy),  32'(vt[i].busy));
            check($sformatf("tbl_done[%0d]", i),  32'(bus.done),  32'(vt[i].done));
        end

        // Asynchronous reset in the middle of HIGH
        bus.req = 4'b0001;
        tick(); tick(); tick();
        check("pre_rst_wave", 32'(bus.wave), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_wave",  32'(bus.wave),  32'h0);
        check("mid_rst_grant", 32'(bus.grant), 32'h0);
        check("mid_rst_busy",  32'(bus.busy),  32'h0);
        check("mid_rst_done",  32'(bus.done),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_grant", 32'(bus.grant), 32'h1);
        bus.req = '0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Round robin, all four requesting, hp=0 reps=0
        for (int i = 0; i < N; i++) set_cfg(i, 0, 0);
        bus.req = 4'b1111;
        for (int o = 0; o < N; o++) begin
            oh = 4'b0001 << o;
            tick();
            check($sformatf("rr_load_grant[%0d]", o), 32'(bus.grant), 32'(oh));
            check($sformatf("rr_load_wave[%0d]", o),  32'(bus.wave),  32'h0);
            tick();
            check($sformatf("rr_high_wave[%0d]", o),  32'(bus.wave),  32'h1);
            tick();
            check($sformatf("rr_low_grant[%0d]", o),  32'(bus.grant), 32'(oh));
            tick();
            check($sformatf("rr_done[%0d]", o),       32'(bus.done),  32'(oh));
            bus.req[o] = 1'b0;
            tick();
            check($sformatf("rr_idle_busy[%0d]", o),  32'(bus.busy),  32'h0);
        end

        // Requester 0 re-requests while 2 waits: 2 must win before 0 again
        bus.req = 4'b0101;
        tick();
        check("rq_first_grant", 32'(bus.grant), 32'h1);
        run_to_done(3);
        check("rq_first_done", 32'(bus.done), 32'h1);
        tick();
        check("rq_turnaround_busy", 32'(bus.busy), 32'h0);
        tick();
        check("rq_second_grant", 32'(bus.grant), 32'h4);
        run_to_done(3);
        check("rq_second_done", 32'(bus.done), 32'h4);
        bus.req[2] = 1'b0;
        tick();
        tick();
        check("rq_third_grant", 32'(bus.grant), 32'h1);
        run_to_done(3);
        check("rq_third_done", 32'(bus.done), 32'h1);
        bus.req = '0;
        tick();

        // Config changed mid-sequence must not affect phase lengths
        set_cfg(0, 2, 0);
        bus.req = 4'b0001;
        tick();
        tick();
        set_cfg(0, 5, 0);
        n = 0;
        while (bus.wave === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        check("cfg_high_len", 32'(n), 32'd3);
        n = 0;
        while (bus.wave === 1'b0 && bus.done === 4'b0000 && n < 20) begin
            n++;
            tick();
        end
        check("cfg_low_len", 32'(n), 32'd3);
        check("cfg_done", 32'(bus.done), 32'h1);
        bus.req = '0;
        tick();
        check("cfg_idle_busy", 32'(bus.busy), 32'h0);

`ifdef SLOW_TICK_SCHED_ABORT_EN
        set_cfg(1, 3, 2);
        bus.req = 4'b0010;
        tick();
        tick();
        tick();
        check("ab_pre_wave", 32'(bus.wave), 32'h1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("ab_wave", 32'(bus.wave), 32'h0);
        check("ab_done", 32'(bus.done), 32'h2);
        bus.req = '0;
        tick();
        check("ab_idle_busy", 32'(bus.busy), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/slow_tick_sched.md
# slow_tick_sched

Shared slow-waveform scheduler. It owns one programmable rate divider and time-shares it between `N_REQ` requesters using round-robin arbitration. For each granted request it generates a square wave with the requester's half-period and repetition count, then returns a one-cycle `done` pulse. It sits between the LED/indicator clients and the single `wave` output line, replacing one hard-wired divider per client.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `CNT_W`, default 8: half-period counter width.
- `REP_W`, default 4: repetition counter width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in N_REQ: level request per requester; held until its `done`.
- `half_period` in N_REQ*CNT_W: per-requester field `[i*CNT_W +: CNT_W]`; each phase lasts value+1 cycles.
- `reps` in N_REQ*REP_W: per-requester field; the request produces value+1 full periods.
- `grant` out N_REQ: one-hot owner; all zero when idle.
- `wave` out 1: shared square-wave output.
- `busy` out 1: high in every state except IDLE.
- `done` out N_REQ: one-cycle pulse to the owner on completion.

## Operation
- States: IDLE, LOAD, HIGH, LOW, DONE. Moore outputs, decoded from registered state and owner.
- IDLE: if any `req` bit is set, the round-robin pick starts searching at `last+1`. The FSM captures the winner index, `half_period` and `reps`, then moves to LOAD. If no request is pending, it stays in IDLE.
- LOAD (1 cycle): `grant[owner]`=1, `wave`=0. Clears the phase counter and repetition counter. Next state is HIGH.
- HIGH: `wave`=1. The phase counter increments each cycle. When counter == captured hp, the counter clears and the FSM moves to LOW.
- LOW: `wave`=0. When counter == hp:
  - If rep_cnt == captured reps, go to DONE.
  - Otherwise, rep_cnt++ and return to HIGH.
- DONE (1 cycle): `done[owner]`=1, `grant[owner]` still 1. The FSM updates `last` to owner, then returns to IDLE.
- Config is captured only at IDLE→LOAD. Later changes to `half_period`/`reps` are ignored.
- If the owner deasserts `req` mid-sequence, the change is ignored and the sequence completes.
- If `req[owner]` is still high in IDLE after DONE, it counts as a new request. It is arbitrated normally, so the other pending requesters win first.
- Counters use equality compares only, so there is no overflow. hp=0 gives 1-cycle phases; reps=0 gives exactly one period.
- Reset (any time, including mid-sequence):
  - State returns to IDLE.
  - `grant`, `wave`, `busy`, `done` go to 0.
  - Counters clear.
  - `last` is set to N_REQ-1, so requester 0 has first priority.

## Timing
- `req` sampled at edge E. LOAD is visible after E (`grant`, `busy` high). `wave` rises after E+1.
- HIGH and LOW each last hp+1 cycles.
- DONE is visible after E+1+2*(hp+1)*(reps+1). IDLE follows one edge later.
- Minimum request-to-request turnaround: an IDLE cycle always sits between DONE and the next LOAD.
- Reset is asynchronous: outputs go low without waiting for `clk`. The first arbitration happens on the first edge after `rst` falls.

## Configuration
- `SLOW_TICK_SCHED_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - `abort`=1 sampled in LOAD/HIGH/LOW sends the FSM to DONE on the next edge: `wave`=0, `done[owner]` pulses, `last` updates.
  - `abort` is ignored in IDLE and DONE.
- Macro undefined: no `abort` port; sequences always run to completion.

## Structure
- Package `slow_tick_pkg`:
  - State enum typedef `sts_state_t` (IDLE, LOAD, HIGH, LOW, DONE).
  - Constant `STS_MAX_REQ`=8.
- Sub-module `rr_arbiter`: combinational. Takes `req` and `last`, returns one-hot `pick` plus a `valid` flag. It is parameterized by N_REQ and instantiated once.
- The FSM, counters, config capture and output decode live in `slow_tick_sched`.

## Test plan
- Reset mid-HIGH (`rst`=1 between edges) → `wave`, `grant`, `busy`, `done` all 0 before the next edge. After release, `req`=0001 gives grant 0001.
- `req`=0001, hp=2, reps=1, sampled at edge 1:
  - `wave` high after edges 2–4, low after 5–7, high after 8–10, low after 11–13.
  - `done`=0001 after edge 14; `busy`=0 after edge 15.
- `req`=1111 held, hp=0, reps=0, each requester dropping its `req` after its `done` → grant order 0001, 0010, 0100, 1000. Each grant lasts 4 cycles (LOAD, HIGH, LOW, DONE).
- Requester 0 keeps `req` high after its `done` while `req[2]`=1 → next grant 0100, then 0001.
- `half_period[0]` changed from 2 to 5 during HIGH → phase lengths stay at 3 cycles.
- With `SLOW_TICK_SCHED_ABORT_EN`, `abort`=1 for one cycle in the second HIGH cycle → `wave`=0 and `done[owner]`=1 after the next edge, then IDLE. Without the macro, the same bench compiles without driving `abort`.
